// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C EEPROM target: FSM states and bus-level constants.
// States are plain localparams so older code can keep comparing against raw codes.
package i2c_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_WADDR    = 3'd3;
  localparam logic [2:0] ST_WDATA    = 3'd4;
  localparam logic [2:0] ST_RDATA    = 3'd5;
  localparam logic [2:0] ST_RACK     = 3'd6;
  // ACK driven for a word-address or data byte; always resumes in WDATA
  localparam logic [2:0] ST_ACK_HOLD = 3'd7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer plus previous-value flop for SCL/SDA; decodes SCL edges and
// START/STOP in the clk after the level is synchronized (2-3 clk from the pins).
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0] metastable stage, [1] synchronized level, [2] previous synchronized level
  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  always_comb begin
    scl_d = {scl_q[1:0], scl_i};
    sda_d = {sda_q[1:0], sda_i};
  end

  // Reset to the idle-bus level so no edge is seen when reset releases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign scl       = scl_q[1];
  assign sda       = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_eeprom_target.sv
// I2C target modelling a 2**AW byte EEPROM with an auto-incrementing word pointer.
// Bits are sampled on SCL rise, SDA drive changes only on SCL fall; START/STOP win.
module i2c_eeprom_target #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         AW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  import i2c_pkg::*;

  localparam int DEPTH = 1 << AW;

  logic scl_lvl, sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl       (scl_lvl),
    .sda       (sda_lvl),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  logic unused_scl_lvl;
  assign unused_scl_lvl = scl_lvl;

  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          mack_q, mack_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_valid_q, wr_valid_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    mack_d     = mack_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_d      = mem_q;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ST_ADDR, ST_WADDR, ST_WDATA: begin
          if (cnt_q < 4'd8) begin
            shift_d = {shift_q[6:0], sda_lvl};
            cnt_d   = cnt_q + 4'd1;
          end
        end
        ST_RACK: begin
          mack_d = sda_lvl;
          cnt_d  = 4'd1;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR: begin
          if (cnt_q == 4'd8) begin
            if (shift_q[7:1] == DEV_ADDR) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shift_q[0];
              state_d  = ST_ADDR_ACK;
            end else begin
              state_d  = ST_IDLE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (rw_q == RW_READ) begin
            shift_d  = mem_q[ptr_q];
            sda_oe_d = ~mem_q[ptr_q][7];
            cnt_d    = 4'd1;
            state_d  = ST_RDATA;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = ST_WADDR;
          end
        end
        ST_WADDR: begin
          if (cnt_q == 4'd8) begin
            ptr_d    = shift_q[AW-1:0];
            sda_oe_d = 1'b1;
            state_d  = ST_ACK_HOLD;
          end
        end
        ST_WDATA: begin
          if (cnt_q == 4'd8) begin
            mem_d[ptr_q] = shift_q;
            wr_valid_d   = 1'b1;
            wr_addr_d    = ptr_q;
            wr_data_d    = shift_q;
            ptr_d        = ptr_q + 1'b1;
            sda_oe_d     = 1'b1;
            state_d      = ST_ACK_HOLD;
          end
        end
        ST_ACK_HOLD: begin
          sda_oe_d = 1'b0;
          cnt_d    = 4'd0;
          state_d  = ST_WDATA;
        end
        ST_RDATA: begin
          // cnt counts bits already put on the bus; bit7 went out on entry
          if (cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            ptr_d    = ptr_q + 1'b1;
            cnt_d    = 4'd0;
            state_d  = ST_RACK;
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
            cnt_d    = cnt_q + 4'd1;
          end
        end
        ST_RACK: begin
          if (cnt_q == 4'd1) begin
            if (mack_q == I2C_ACK) begin
              shift_d  = mem_q[ptr_q];
              sda_oe_d = ~mem_q[ptr_q][7];
              cnt_d    = 4'd1;
              state_d  = ST_RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= '0;
      rw_q       <= RW_WRITE;
      mack_q     <= I2C_NACK;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      mem_q      <= '{default: 8'h00};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      mem_q      <= mem_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Directed bench: bit-banged I2C master against i2c_eeprom_target with hand-computed
// expected bytes, ACKs and write pulses.
module tb_i2c_eeprom_target;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_oe, busy, wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       sda_bus;

  int checks = 0;
  int failures = 0;

  int         wr_cnt = 0;
  logic [3:0] wr_a [64];
  logic [7:0] wr_d [64];

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_eeprom_target #(.DEV_ADDR(7'h50), .AW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_a[wr_cnt % 64] = wr_addr;
      wr_d[wr_cnt % 64] = wr_data;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic s);
    sda_m = b;
    wq(Q);
    scl_m = 1'b1;
    wq(Q);
    s = sda_bus;
    scl_m = 1'b0;
    wq(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wq(Q);
    scl_m = 1'b1;
    wq(Q);
    sda_m = 1'b0;
    wq(Q);
    scl_m = 1'b0;
    wq(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wq(Q);
    scl_m = 1'b1;
    wq(Q);
    sda_m = 1'b1;
    wq(Q);
  endtask

  task automatic wb(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, ack);
  endtask

  task automatic rb(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      d[i] = s;
    end
    bit_io(mack, s);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wq(4);
    checks++;
    if ({sda_oe, busy, wr_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000", {sda_oe, busy, wr_valid});
    end
    checks++;
    if ({wr_addr, wr_data} !== 12'h000) begin
      failures++;
      $display("FAIL reset_wr got=%h exp=000", {wr_addr, wr_data});
    end
    rst = 1'b0;
    wq(4);
    checks++;
    if ({sda_oe, busy, wr_valid} !== 3'b000) begin
      failures++;
      $display("FAIL post_reset_ctrl got=%b exp=000", {sda_oe, busy, wr_valid});
    end
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int n0 = wr_cnt;
    i2c_start();
    wb(8'hA0, a0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL write_busy got=%b exp=1", busy);
    end
    wb(8'h03, a1);
    wb(8'hA5, a2);
    i2c_stop();
    checks++;
    if ({a0, a1, a2} !== 3'b000) begin
      failures++;
      $display("FAIL write_acks got=%b exp=000", {a0, a1, a2});
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL write_busy_stop got=%b exp=0", busy);
    end
    checks++;
    if (wr_cnt - n0 !== 1) begin
      failures++;
      $display("FAIL write_pulses got=%0d exp=1", wr_cnt - n0);
    end
    checks++;
    if ({wr_a[n0 % 64], wr_d[n0 % 64]} !== 12'h3A5) begin
      failures++;
      $display("FAIL write_pulse_dat got=%h exp=3a5", {wr_a[n0 % 64], wr_d[n0 % 64]});
    end
  endtask

  task automatic test_random_read();
    logic a0, a1, a2, a3, a4, a5, a6;
    logic [7:0] d0, d1;
    int n0;
    i2c_start();
    wb(8'hA0, a0);
    wb(8'h04, a1);
    wb(8'h3C, a2);
    i2c_stop();
    n0 = wr_cnt;
    i2c_start();
    wb(8'hA0, a3);
    wb(8'h03, a4);
    i2c_start();
    wb(8'hA1, a5);
    rb(1'b1, d0);
    i2c_stop();
    checks++;
    if (d0 !== 8'hA5) begin
      failures++;
      $display("FAIL rand_read got=%h exp=a5", d0);
    end
    checks++;
    if (wr_cnt - n0 !== 0) begin
      failures++;
      $display("FAIL rand_read_nowr got=%0d exp=0", wr_cnt - n0);
    end
    // current-address read shows the pointer moved on to word 4
    i2c_start();
    wb(8'hA1, a6);
    rb(1'b1, d1);
    i2c_stop();
    checks++;
    if (d1 !== 8'h3C) begin
      failures++;
      $display("FAIL ptr_after_read got=%h exp=3c", d1);
    end
    checks++;
    if ({a0, a1, a2, a3, a4, a5, a6} !== 7'b0) begin
      failures++;
      $display("FAIL rand_read_acks got=%b exp=0000000", {a0, a1, a2, a3, a4, a5, a6});
    end
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    int n0 = wr_cnt;
    i2c_start();
    wb(8'hA0, a0);
    wb(8'h0F, a1);
    wb(8'h11, a2);
    wb(8'h22, a3);
    i2c_stop();
    checks++;
    if ({a0, a1, a2, a3} !== 4'b0000) begin
      failures++;
      $display("FAIL wrap_acks got=%b exp=0000", {a0, a1, a2, a3});
    end
    checks++;
    if (wr_cnt - n0 !== 2) begin
      failures++;
      $display("FAIL wrap_pulses got=%0d exp=2", wr_cnt - n0);
    end
    checks++;
    if ({wr_a[n0 % 64], wr_d[n0 % 64], wr_a[(n0 + 1) % 64], wr_d[(n0 + 1) % 64]} !== 24'hF11022) begin
      failures++;
      $display("FAIL wrap_pulse_dat got=%h exp=f11022",
               {wr_a[n0 % 64], wr_d[n0 % 64], wr_a[(n0 + 1) % 64], wr_d[(n0 + 1) % 64]});
    end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int n0 = wr_cnt;
    i2c_start();
    wb(8'hA2, a0);
    checks++;
    if ({a0, busy, sda_oe} !== 3'b100) begin
      failures++;
      $display("FAIL mismatch_nack got=%b exp=100", {a0, busy, sda_oe});
    end
    i2c_stop();
    i2c_start();
    wb(8'hA0, a1);
    checks++;
    if ({a1, busy} !== 2'b01) begin
      failures++;
      $display("FAIL mismatch_recover got=%b exp=01", {a1, busy});
    end
    i2c_stop();
    checks++;
    if ({busy, wr_cnt - n0 == 0} !== 2'b01) begin
      failures++;
      $display("FAIL mismatch_idle got=%b exp=01", {busy, wr_cnt - n0 == 0});
    end
  endtask

  task automatic test_seq_read();
    logic a0, a1, a2, a3, a4, a5, a6;
    logic [7:0] d0, d1, d2;
    int n0 = wr_cnt;
    i2c_start();
    wb(8'hA0, a0);
    wb(8'h0E, a1);
    wb(8'h96, a2);
    i2c_stop();
    checks++;
    if ({wr_a[n0 % 64], wr_d[n0 % 64]} !== 12'hE96) begin
      failures++;
      $display("FAIL seq_setup_wr got=%h exp=e96", {wr_a[n0 % 64], wr_d[n0 % 64]});
    end
    i2c_start();
    wb(8'hA0, a3);
    wb(8'h0E, a4);
    i2c_start();
    wb(8'hA1, a5);
    rb(1'b0, d0);
    rb(1'b0, d1);
    rb(1'b1, d2);
    checks++;
    if ({d0, d1, d2} !== 24'h961122) begin
      failures++;
      $display("FAIL seq_read got=%h exp=961122", {d0, d1, d2});
    end
    checks++;
    if ({sda_oe, busy} !== 2'b01) begin
      failures++;
      $display("FAIL seq_read_nack got=%b exp=01", {sda_oe, busy});
    end
    i2c_stop();
    a6 = busy;
    checks++;
    if ({a0, a1, a2, a3, a4, a5, a6} !== 7'b0) begin
      failures++;
      $display("FAIL seq_read_acks_busy got=%b exp=0000000", {a0, a1, a2, a3, a4, a5, a6});
    end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, a3, a4, a5;
    logic [7:0] d0, d1;
    i2c_start();
    wb(8'hA0, a0);
    wb(8'h04, a1);
    i2c_start();
    wb(8'hA1, a2);
    // word 4 holds 0x3C, so bit7 (0) is being driven now
    checks++;
    if ({a0, a1, a2, sda_oe} !== 4'b0001) begin
      failures++;
      $display("FAIL mid_read_drive got=%b exp=0001", {a0, a1, a2, sda_oe});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({sda_oe, busy, wr_valid, wr_addr, wr_data} !== 15'h0) begin
      failures++;
      $display("FAIL mid_read_reset got=%h exp=0000", {sda_oe, busy, wr_valid, wr_addr, wr_data});
    end
    scl_m = 1'b1;
    sda_m = 1'b1;
    wq(4);
    rst = 1'b0;
    wq(4);
    i2c_start();
    wb(8'hA0, a3);
    wb(8'h00, a4);
    i2c_start();
    wb(8'hA1, a5);
    rb(1'b0, d0);
    rb(1'b1, d1);
    i2c_stop();
    checks++;
    if ({a3, a4, a5, d0, d1} !== 19'h0) begin
      failures++;
      $display("FAIL mem_cleared got=%h exp=00000", {a3, a4, a5, d0, d1});
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_random_read();
    test_wrap();
    test_mismatch();
    test_seq_read();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
